poly_encode12: RTL and testbench
================================

# poly_encode12

Streaming ByteEncode_12 packer for Kyber-768-90s. It takes a polynomial of N 12-bit coefficients and serialises it into 3·N/2 bytes, little-endian, two coefficients per three bytes. It sits before the byte-level serialisation of public keys and ciphertexts, and is the inverse of the existing 12-bit decode path, so its output bytes fed to that decoder must reproduce the input coefficients. Input and output each use a valid/ready handshake, and a frame ends with `out_last` plus a `done` pulse.

## Interface
- `Q`, default 3329: modulus used for the optional canonical reduction.
- `N`, default 256: coefficients per polynomial; must be even.
- `REDUCE`, default 1: 1 maps an input c with Q ≤ c ≤ 4095 to c−Q before packing; 0 packs the raw 12 bits.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  coefficient present on `in_coeff`.
- `in_coeff`  in  12  coefficient value.
- `in_ready`  out  1  block accepts a coefficient this cycle.
- `out_valid`  out  1  byte present on `out_data`.
- `out_data`  out  8  packed byte.
- `out_ready`  in  1  downstream accepts byte.
- `out_last`  out  1  qualifies the final byte (index 3N/2−1) of a polynomial.
- `done`  out  1  one-cycle pulse after the final byte handshake.

## Operation
- Handshakes complete on a rising edge where valid and ready are both high.
- Reduction is combinational on input: r = (REDUCE && c ≥ Q) ? c−Q : c.
- Internal state:
  - 24-bit pair register `{c1,c0}`.
  - FSM: COLLECT0, COLLECT1, EMIT.
  - 2-bit `byte_sel` (0..2).
  - Coefficient counter, log2(N) bits.
  - Byte counter, 0..3N/2−1.
- COLLECT0:
  - `in_ready`=1.
  - On input handshake, store r as c0 and go to COLLECT1.
- COLLECT1:
  - `in_ready`=1.
  - On input handshake, store r as c1, set `byte_sel`=0 and go to EMIT.
- EMIT:
  - `in_ready`=0 and `out_valid`=1.
  - `byte_sel`=0 → `out_data`=c0[7:0].
  - `byte_sel`=1 → `out_data`={c1[3:0], c0[11:8]}.
  - `byte_sel`=2 → `out_data`=c1[11:4].
  - On output handshake, increment `byte_sel` and the byte counter.
  - After the handshake with `byte_sel`=2, return to COLLECT0.
- `out_last`=1 only while in EMIT with byte counter = 3N/2−1.
- On that handshake:
  - The byte and coefficient counters wrap to 0.
  - `done` pulses for the next cycle only.
  - The next polynomial starts without any additional command.
- `in_valid` while `in_ready`=0 is ignored; `in_coeff` is not sampled.
- `out_data` and `out_last` are registered and held stable while `out_valid`=1 and `out_ready`=0.
- `out_ready` outside EMIT has no effect.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM → COLLECT0; all counters and the pair register cleared.
  - `in_ready`=0 while `rst` is asserted, 1 from the first cycle after release.
  - `out_valid`=0, `out_data`=0x00, `out_last`=0, `done`=0.
- Latency: c1 accepted at edge k → `out_valid`=1 with byte 0 in the cycle after edge k.
- With `out_ready` held high, byte 0/1/2 handshakes occur at edges k+1, k+2 and k+3, and `in_ready` returns to 1 in the cycle after edge k+3.
- Throughput: 2 coefficients per 5 cycles with no stalls; N=256 takes 640 cycles from the first input handshake to the last output handshake.
- `done` is high exactly in the cycle after the last byte handshake; `in_ready` is also 1 in that cycle, so the next polynomial's c0 may be accepted concurrently.
- Reset mid-frame aborts the frame:
  - Partial bytes are discarded and no `done` is issued.
  - The next frame restarts at coefficient 0 and byte 0.

## Test plan
- Reset values: hold `rst`=0 with random inputs → `out_valid`=0, `out_data`=0x00, `out_last`=0, `done`=0, `in_ready`=0; after release, `in_ready`=1.
- Single pair: c0=0x123, c1=0xABC, `out_ready`=1 → bytes 0x23, 0xC1, 0xAB on three consecutive cycles starting one cycle after c1 is accepted.
- Reduction (REDUCE=1): c0=4095, c1=3329 → bytes 0xFE, 0x02, 0x00; with c0=3328, c1=0 the bytes are 0x00, 0x0D, 0x00 (no reduction at Q−1).
- Backpressure: toggle `out_ready` pseudo-randomly and hold `in_valid`=1 → bytes unchanged while stalled, no byte lost or duplicated, `in_ready`=0 throughout EMIT.
- Full frame: N=256, coefficient i = (i·13) mod Q, `out_ready`=1 →
  - 384 bytes matching the packing rule;
  - `out_last` only on byte 383;
  - one `done` pulse, 640 cycles after the first input handshake.
- Round-trip and recovery:
  - Feed the encoder output into the 12-bit decoder; all 256 coefficients must match.
  - Assert `rst` after byte 100 of a frame, then send a fresh frame → correct 384 bytes and exactly one `done`.

Source files
------------

// File: rtl/poly_encode12_if.sv
// poly_encode12_if: handshake bundle for the 12-bit coefficient packer.
//   in_valid/in_coeff/in_ready    : coefficient stream into the packer
//   out_valid/out_data/out_ready  : packed byte stream out of the packer
//   out_last                      : qualifies the final byte of a polynomial
//   done                          : one-cycle pulse after the final byte handshake
// master = producer/consumer side (testbench/system), slave = packer.
interface poly_encode12_if;
  logic        in_valid;
  logic [11:0] in_coeff;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        out_last;
  logic        done;

  modport master (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_data, out_last, done
  );

  modport slave (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/poly_encode12.sv
// poly_encode12: streaming ByteEncode_12 packer. Collects two 12-bit
// coefficients {c1,c0} and emits them as three little-endian bytes; a
// polynomial of N coefficients yields 3N/2 bytes, the last flagged by
// out_last, followed by a one-cycle done pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - poly_encode12_if.slave (coefficient in, byte out, out_last, done)
// Parameters: Q (modulus), N (coefficients per polynomial, even),
//             REDUCE (1: map Q..4095 to c-Q before packing).
module poly_encode12 #(
  parameter int Q      = 3329,
  parameter int N      = 256,
  parameter int REDUCE = 1
) (
  input logic            clk,
  input logic            rst,
  poly_encode12_if.slave bus
);

  localparam int NBYTES = 3 * N / 2;
  localparam int BW     = $clog2(NBYTES);
  localparam int CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [11:0]   QV       = 12'(Q);
  localparam logic [BW-1:0] LAST_IDX = BW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_COE = CW'(N - 1);

  typedef enum logic [1:0] {COLLECT0, COLLECT1, EMIT} state_t;

  state_t        state_q, state_d;
  logic [11:0]   c0_q, c0_d, c1_q, c1_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] coef_q, coef_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  // Holds in_ready low through reset and until the first edge after release.
  logic          run_q;

  logic [11:0]   r;
  logic          in_ready, out_valid, in_hs, out_hs, last_byte;

  always_comb begin
    r = bus.in_coeff;
    if (REDUCE != 0 && bus.in_coeff >= QV) r = bus.in_coeff - QV;
  end

  assign in_ready  = run_q && (state_q != EMIT);
  assign out_valid = (state_q == EMIT);
  assign in_hs     = bus.in_valid && in_ready;
  assign out_hs    = out_valid && bus.out_ready;
  assign last_byte = (byte_q == LAST_IDX);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;

  // out_data/out_last are registered: the next byte is loaded on the edge
  // that enters EMIT or completes the previous byte handshake.
  always_comb begin
    state_d = state_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    sel_d   = sel_q;
    coef_d  = coef_q;
    byte_d  = byte_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      COLLECT0: begin
        if (in_hs) begin
          c0_d    = r;
          coef_d  = (coef_q == LAST_COE) ? '0 : coef_q + 1'b1;
          state_d = COLLECT1;
        end
      end
      COLLECT1: begin
        if (in_hs) begin
          c1_d    = r;
          coef_d  = (coef_q == LAST_COE) ? '0 : coef_q + 1'b1;
          sel_d   = 2'd0;
          data_d  = c0_q[7:0];
          last_d  = last_byte;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_hs) begin
          byte_d = last_byte ? '0 : byte_q + 1'b1;
          done_d = last_byte;
          if (last_byte) coef_d = '0;
          case (sel_q)
            2'd0: begin
              sel_d  = 2'd1;
              data_d = {c1_q[3:0], c0_q[11:8]};
              last_d = (byte_d == LAST_IDX);
            end
            2'd1: begin
              sel_d  = 2'd2;
              data_d = c1_q[11:4];
              last_d = (byte_d == LAST_IDX);
            end
            default: begin
              sel_d   = 2'd0;
              last_d  = 1'b0;
              state_d = COLLECT0;
            end
          endcase
        end
      end
      default: state_d = COLLECT0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT0;
      c0_q    <= '0;
      c1_q    <= '0;
      sel_q   <= '0;
      coef_q  <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      sel_q   <= sel_d;
      coef_q  <= coef_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_poly_encode12.sv
// tb_poly_encode12: randomized/directed bench for poly_encode12 with a
// byte-queue reference model (pairs packed as c0 + 4096*c1, little-endian)
// and a 12-bit decoder applied to each completed frame.
module tb_poly_encode12;
  localparam int Q  = 3329;
  localparam int N  = 256;
  localparam int NB = 3 * N / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  poly_encode12_if bus();

  poly_encode12 #(.Q(Q), .N(N), .REDUCE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit bp_mode = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int red(input int c);
    return (c >= Q) ? c - Q : c;
  endfunction

  // ---------------- reference model / monitor ----------------
  int   exp_q[$];
  int   exp_coef[N];
  int   got_byte[NB];
  int   pend_c0, cidx, bidx, bytes_seen, done_cnt;
  int   frame_start_edge, last_edge, mr, me, d0, d1;
  bit   pend, done_exp, stall_prev;
  logic [7:0] data_prev;
  logic       last_prev;

  initial begin
    pend = 0; cidx = 0; bidx = 0; bytes_seen = 0; done_cnt = 0;
    done_exp = 0; stall_prev = 0; frame_start_edge = 0; last_edge = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pend = 0; cidx = 0; bidx = 0; done_exp = 0; stall_prev = 0;
    end else begin
      check("done", bus.done, done_exp);
      if (bus.done === 1'b1) done_cnt++;
      done_exp = 0;
      if (stall_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, data_prev);
        check("hold_last", bus.out_last, last_prev);
      end
      if (bus.out_valid === 1'b1) check("in_ready_emit", bus.in_ready, 0);
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        mr = red(int'(bus.in_coeff));
        if (cidx == 0) frame_start_edge = cyc + 1;
        exp_coef[cidx] = mr;
        cidx = (cidx + 1) % N;
        if (!pend) begin
          pend_c0 = mr; pend = 1;
        end else begin
          me = pend_c0 + mr * 4096;
          for (int j = 0; j < 3; j++) exp_q.push_back((me >> (8 * j)) & 255);
          pend = 0;
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        me = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h7FFF_FFFF;
        check("byte", bus.out_data, me);
        check("last", bus.out_last, bidx == NB - 1);
        got_byte[bidx] = int'(bus.out_data);
        bytes_seen++;
        if (bidx == NB - 1) begin
          last_edge = cyc + 1;
          done_exp = 1;
          for (int k = 0; k < N / 2; k++) begin
            d0 = got_byte[3*k] | ((got_byte[3*k+1] & 15) << 8);
            d1 = (got_byte[3*k+1] >> 4) | (got_byte[3*k+2] << 4);
            check("roundtrip_c0", d0, exp_coef[2*k]);
            check("roundtrip_c1", d1, exp_coef[2*k+1]);
          end
          bidx = 0;
        end else begin
          bidx++;
        end
      end
      stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      data_prev  = bus.out_data;
      last_prev  = bus.out_last;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int c);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_coeff = 12'(c);
    do begin
      @(negedge clk); t++;
    end while (bus.in_ready !== 1'b1 && t < 2000);
    if (t >= 2000) check("send_timeout", t, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_pair_chk(input int c0, input int c1,
                               input int b0, input int b1, input int b2);
    send(c0);
    send(c1);
    bus.in_valid = 1'b0;
    check("lat_valid", bus.out_valid, 1);
    check("lat_b0", bus.out_data, b0);
    check("lat_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    check("lat_b1", bus.out_data, b1);
    @(posedge clk); #1;
    check("lat_b2", bus.out_data, b2);
    @(posedge clk); #1;
    check("pair_ready_back", bus.in_ready, 1);
    check("pair_valid_off", bus.out_valid, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int d_before, input string tag);
    int t = 0;
    while (done_cnt == d_before && t < 400) begin
      @(posedge clk); #1; t++;
    end
    repeat (5) @(posedge clk);
    #1 check(tag, done_cnt - d_before, 1);
  endtask

  int dstart, bstart, tw;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_coeff = '0;
    // Reset values with random inputs while rst is held low.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_coeff = 12'($urandom_range(0, 4095));
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_done", bus.done, 0);
      check("rst_in_ready", bus.in_ready, 0);
    end
    bp_mode = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Directed pairs: packing and reduction boundaries.
    send_pair_chk(12'h123, 12'hABC, 8'h23, 8'hC1, 8'hAB);
    send_pair_chk(4095, 3329, 8'hFE, 8'h02, 8'h00);
    send_pair_chk(3328, 0, 8'h00, 8'h0D, 8'h00);

    // Complete frame 0 under random backpressure with in_valid held high.
    bp_mode = 1'b1;
    dstart = done_cnt;
    for (int i = 6; i < N; i++) send($urandom_range(0, 4095));
    bus.in_valid = 1'b0;
    bp_mode = 1'b0;
    wait_done(dstart, "bp_frame_done");

    // Full frame, coefficient i = 13*i mod Q, no stalls.
    do_reset();
    dstart = done_cnt;
    for (int i = 0; i < N; i++) send((i * 13) % Q);
    bus.in_valid = 1'b0;
    wait_done(dstart, "full_frame_done");
    // First input edge to last byte edge spans 640 cycles inclusive.
    check("full_frame_span", last_edge - frame_start_edge, 639);

    // Abort mid-frame after byte 100, then send a fresh frame.
    do_reset();
    dstart = done_cnt;
    bstart = bytes_seen;
    for (int i = 0; i < 68; i++) send($urandom_range(0, 4095));
    bus.in_valid = 1'b0;
    tw = 0;
    while (bytes_seen - bstart < 101 && tw < 200) begin
      @(posedge clk); #1; tw++;
    end
    check("abort_bytes_reached", (bytes_seen - bstart) >= 101, 1);
    do_reset();
    check("abort_no_done", done_cnt - dstart, 0);
    dstart = done_cnt;
    bstart = bytes_seen;
    for (int i = 0; i < N; i++) send($urandom_range(0, 4095));
    bus.in_valid = 1'b0;
    wait_done(dstart, "fresh_frame_done");
    check("fresh_frame_bytes", bytes_seen - bstart, NB);
    check("model_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
